imem_fetch_responder: RTL

Responder end of the instruction-fetch interface: accepts fetch requests (PC) from the IF stage of `cpu`, reads a word-addressed instruction memory, and returns the instruction in order after a fixed pipelined latency. It provides request back-pressure, a flush for branch/jump redirects, and a preload port used by testbenches and the boot loader to fill the memory before the core runs.

---
 rtl/imem_fetch_responder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// Instruction-fetch responder: word-addressed instruction memory with a fixed-latency read
// pipeline, an in-order response queue, flush and preload. Define IMEM_PARITY_EN for per-word parity.
module imem_fetch_responder #(
    parameter int DEPTH_WORDS     = 1024,
    parameter int LATENCY         = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_addr,
    output logic        rsp_fault,
    input  logic        flush,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
`ifdef IMEM_PARITY_EN
    ,
    input  logic        inject_par_err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0] mem [DEPTH_WORDS];
`ifdef IMEM_PARITY_EN
    logic        mem_par [DEPTH_WORDS];
`endif

    logic [LATENCY-1:0] st_valid;
    logic [LATENCY-1:0] st_fault;
    logic [31:0]        st_addr  [LATENCY];
    logic [31:0]        st_instr [LATENCY];

    logic [31:0]          q_addr  [MAX_OUTSTANDING];
    logic [31:0]          q_instr [MAX_OUTSTANDING];
    logic [MAX_OUTSTANDING-1:0] q_fault;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [CW-1:0]        q_count;
    logic [CW-1:0]        outstanding;

    logic          accept;
    logic          consume;
    logic          push;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] load_idx;
    logic          load_in_range;
    logic          addr_fault;
    logic          par_err;
    logic          req_fault;
    logic [31:0]   rd_word;
    logic [31:0]   req_instr;
    logic          unused_load_lsbs;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    assign req_ready = reset && !flush && (outstanding < CW'(MAX_OUTSTANDING));
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (q_count != '0);
    assign consume   = rsp_valid && rsp_ready;
    assign push      = st_valid[LATENCY-1];

    assign rsp_instr = q_instr[rd_ptr];
    assign rsp_addr  = q_addr[rd_ptr];
    assign rsp_fault = q_fault[rd_ptr];

    assign req_idx          = req_addr[AW+1:2];
    assign load_idx         = load_addr[AW+1:2];
    assign load_in_range    = (load_addr[31:AW+2] == '0);
    assign unused_load_lsbs = ^load_addr[1:0];
    assign addr_fault       = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);
    assign rd_word          = mem[req_idx];

    // Even parity: the stored bit makes data plus parity an even number of ones.
`ifdef IMEM_PARITY_EN
    assign par_err = ((^rd_word) != mem_par[req_idx]);
`else
    assign par_err = 1'b0;
`endif

    assign req_fault = addr_fault || par_err;
    assign req_instr = req_fault ? NOP : rd_word;

    // Memory contents are deliberately outside the reset domain so preloaded code survives reset.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            mem[load_idx] <= load_data;
`ifdef IMEM_PARITY_EN
            mem_par[load_idx] <= (^load_data) ^ inject_par_err;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_valid    <= '0;
            st_fault    <= '0;
            q_fault     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_count     <= '0;
            outstanding <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                st_addr[i]  <= '0;
                st_instr[i] <= '0;
            end
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                q_addr[i]  <= '0;
                q_instr[i] <= '0;
            end
        end else if (flush) begin
            st_valid    <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            q_count     <= '0;
            outstanding <= '0;
        end else begin
            st_valid[0] <= accept;
            st_fault[0] <= req_fault;
            st_addr[0]  <= req_addr;
            st_instr[0] <= req_instr;
            for (int i = 1; i < LATENCY; i++) begin
                st_valid[i] <= st_valid[i-1];
                st_fault[i] <= st_fault[i-1];
                st_addr[i]  <= st_addr[i-1];
                st_instr[i] <= st_instr[i-1];
            end

            // The queue cannot overflow: its occupancy never exceeds the outstanding count.
            if (push) begin
                q_addr[wr_ptr]  <= st_addr[LATENCY-1];
                q_instr[wr_ptr] <= st_instr[LATENCY-1];
                q_fault[wr_ptr] <= st_fault[LATENCY-1];
                wr_ptr          <= ptr_next(wr_ptr);
            end
            if (consume) begin
                rd_ptr <= ptr_next(rd_ptr);
            end

            case ({push, consume})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase

            case ({accept, consume})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule
